pio_in_irq: RTL

Parametrised Avalon-MM input PIO with per-bit edge capture and interrupt generation, the successor to the single-bit button PIO in the lab systems. Samples a WIDTH-bit asynchronous `in_port` (switches, buttons, sensor strobes), synchronises and optionally debounces it, and captures selectable edges per bit. Raises `irq` to the Nios II interrupt controller from masked capture bits (edge mode) or masked input levels (level mode). Sits on the system Avalon bus as a 4-word slave.

---
 rtl/pio_in_pkg.sv | 25 ++
 rtl/pio_in_debounce.sv | 64 ++++++
 rtl/pio_in_irq.sv | 84 ++++++++
 3 files changed

// File: rtl/pio_in_pkg.sv
// Shared constants for the pio_in_irq input PIO: register map, edge-type and irq-mode encodings.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_RESERVED     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned IRQ_EDGE  = 0;
  localparam int unsigned IRQ_LEVEL = 1;

  function automatic logic edge_hit(input int unsigned edge_type, input logic cur,
                                    input logic nxt);
    case (edge_type)
      EDGE_RISING:  return nxt & ~cur;
      EDGE_FALLING: return ~nxt & cur;
      default:      return nxt ^ cur;
    endcase
  endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One input bit: two-flop synchroniser followed by the filter stage.
// PIO_IN_DEBOUNCE_EN selects the counting debounce filter; otherwise the filter is a single flop.
module pio_in_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic filt,
  output logic filt_next
);

  logic s1_q, s2_q, f_q, f_d;

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("pio_in_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      f_q  <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      f_q  <= f_d;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter tracks how long s2 has disagreed with f; any agreement restarts the window.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    if (s2_q == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
      f_d   = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign f_d = s2_q;
`endif

  assign filt      = f_q;
  assign filt_next = f_d;

endmodule

// File: rtl/pio_in_irq.sv
// Avalon-MM input PIO with per-bit edge capture and interrupt generation (4-word slave).
// Optional input debounce is compiled in with PIO_IN_DEBOUNCE_EN.
module pio_in_irq
  import pio_in_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned IRQ_MODE        = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] f_q, f_d, edges, clr_bits;
  logic [WIDTH-1:0] irq_mask_q, edge_capture_q;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  if (WIDTH < 1 || WIDTH > 32) begin : g_param_check
    $error("pio_in_irq: WIDTH must be in 1..32");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .din      (in_port[i]),
      .filt     (f_q[i]),
      .filt_next(f_d[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Edges are taken against the value f is about to load, so capture lands with the f update.
  always_comb begin
    edges = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edges[i] = edge_hit(EDGE_TYPE, f_q[i], f_d[i]);
    end
  end

  assign clr_bits = (wr_en && address == ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:         rd_mux[WIDTH-1:0] = f_d;
      ADDR_IRQ_MASK:     rd_mux[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture_q;
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata       <= '0;
    end else begin
      if (wr_en && address == ADDR_IRQ_MASK) begin
        irq_mask_q <= writedata[WIDTH-1:0];
      end
      // A new edge wins over a simultaneous clear of the same bit.
      edge_capture_q <= (edge_capture_q & ~clr_bits) | edges;
      readdata       <= rd_mux;
    end
  end

  assign irq = (IRQ_MODE == IRQ_LEVEL) ? |(f_q & irq_mask_q) : |(edge_capture_q & irq_mask_q);

endmodule
